// File: rtl/hdmi_infoframe_pkg.sv
// Shared definitions for HDMI InfoFrame receivers: packet geometry, type
// codes, FSM states and the decoded AVI field record.
package hdmi_infoframe_pkg;

    localparam logic [7:0] INFOFRAME_TYPE_AVI     = 8'h82;
    localparam int         INFOFRAME_PACKET_BYTES = 31;
    localparam int         PB_FIRST_INDEX         = 3;
    localparam logic [4:0] LAST_BYTE_INDEX        = 5'(INFOFRAME_PACKET_BYTES - 1);
    localparam logic [7:0] MAX_PB_INDEX           = 8'd27;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_SKIP,
        ST_DONE
    } rx_state_t;

    // Field order follows PB1[6:0], PB2, PB3, PB4, PB5.
    typedef struct packed {
        logic [1:0] video_format;
        logic       active_format_info_present;
        logic [1:0] bar_info;
        logic [1:0] scan_info;
        logic [1:0] colorimetry;
        logic [1:0] picture_aspect_ratio;
        logic [3:0] active_format_aspect_ratio;
        logic       it_content;
        logic [2:0] extended_colorimetry;
        logic [1:0] rgb_quantization_range;
        logic [1:0] non_uniform_picture_scaling;
        logic [7:0] cea;
        logic [1:0] ycc_quantization_range;
        logic [1:0] content_type;
        logic [3:0] pixel_repetition;
    } avi_fields_t;

endpackage

// File: rtl/infoframe_checksum_acc.sv
// 8-bit wrapping byte accumulator for InfoFrame checksums. 'clear' restarts
// the sum (a byte enabled in the same cycle becomes the first term);
// 'in_range' drops bytes past the declared payload length.
module infoframe_checksum_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       in_range,
    input  logic [7:0] data,
    output logic [7:0] sum_next
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;
    logic [7:0] base;

    // Next sum; exported so the owner can judge a packet on its final byte.
    always_comb begin
        base  = clear ? 8'd0 : sum_q;
        sum_d = (enable && in_range) ? base + data : base;
    end

    assign sum_next = sum_d;

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) sum_q <= 8'd0;
        else       sum_q <= sum_d;
    end

endmodule

// File: rtl/avi_info_frame_receiver.sv
// AVI InfoFrame (type 0x82) parser. Takes HB0-HB2, PB0-PB27 one byte per
// valid cycle, checks header and checksum, and publishes decoded fields.
// Optional statistics counters: define AVI_INFO_FRAME_RX_STATS_EN.
module avi_info_frame_receiver
    import hdmi_infoframe_pkg::*;
#(
    parameter logic [7:0] EXPECTED_VERSION = 8'd2,
    parameter logic [4:0] MIN_LENGTH       = 5'd13,
    parameter int         ERR_CNT_WIDTH    = 16
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic       byte_sop,
    input  logic [7:0] byte_data,
    output logic [1:0] video_format,
    output logic       active_format_info_present,
    output logic [1:0] bar_info,
    output logic [1:0] scan_info,
    output logic [1:0] colorimetry,
    output logic [1:0] picture_aspect_ratio,
    output logic [3:0] active_format_aspect_ratio,
    output logic       it_content,
    output logic [2:0] extended_colorimetry,
    output logic [1:0] rgb_quantization_range,
    output logic [1:0] non_uniform_picture_scaling,
    output logic [7:0] cea,
    output logic [1:0] ycc_quantization_range,
    output logic [1:0] content_type,
    output logic [3:0] pixel_repetition,
`ifdef AVI_INFO_FRAME_RX_STATS_EN
    output logic [ERR_CNT_WIDTH-1:0] good_cnt,
    output logic [ERR_CNT_WIDTH-1:0] cksum_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] hdr_err_cnt,
`endif
    output logic       frame_valid,
    output logic       frame_update,
    output logic       err_checksum,
    output logic       err_header
);

    rx_state_t   state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  ver_q, ver_d;
    logic [7:0]  len_q, len_d;
    avi_fields_t shadow_q, shadow_d;
    avi_fields_t live_q, live_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_update_q, frame_update_d;
    logic        err_checksum_q, err_checksum_d;
    logic        err_header_q, err_header_d;

    logic        start, advance, hdr_bad;
    logic        acc_en, acc_in_range;
    logic [7:0]  acc_sum_next, pb_idx, len_clamped;

    // A sop byte restarts parsing from any state; plain bytes only move
    // the packet-consuming states (DONE ignores them).
    assign start   = byte_valid && byte_sop;
    assign advance = byte_valid && !byte_sop &&
                     (state_q == ST_HDR || state_q == ST_BODY || state_q == ST_SKIP);

    assign pb_idx      = {3'b000, idx_q} - 8'(PB_FIRST_INDEX);
    assign len_clamped = (len_q > MAX_PB_INDEX) ? MAX_PB_INDEX : len_q;
    assign hdr_bad     = (ver_q != EXPECTED_VERSION) || (len_q < {3'b000, MIN_LENGTH}) ||
                         (len_q > MAX_PB_INDEX);

    // Header bytes always count; payload bytes only up to the clamped length.
    assign acc_en       = start || (advance && state_q != ST_SKIP);
    assign acc_in_range = start || (state_q == ST_HDR) ||
                          ((state_q == ST_BODY) && (pb_idx <= len_clamped));

    infoframe_checksum_acc u_acc (
        .clk      (clk_pixel),
        .reset    (reset),
        .clear    (start),
        .enable   (acc_en),
        .in_range (acc_in_range),
        .data     (byte_data),
        .sum_next (acc_sum_next)
    );

    // Next-state, capture and verdict logic. The verdict is taken on the
    // PB27 byte so pulses and fields are live during the DONE cycle.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        ver_d          = ver_q;
        len_d          = len_q;
        shadow_d       = shadow_q;
        live_d         = live_q;
        frame_valid_d  = frame_valid_q;
        frame_update_d = 1'b0;
        err_checksum_d = 1'b0;
        err_header_d   = 1'b0;

        if (start) begin
            idx_d   = 5'd1;
            state_d = (byte_data == INFOFRAME_TYPE_AVI) ? ST_HDR : ST_SKIP;
        end else begin
            case (state_q)
                ST_DONE: state_d = ST_IDLE;
                ST_HDR: if (advance) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd1) ver_d = byte_data;
                    if (idx_q == 5'd2) begin
                        len_d   = byte_data;
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: if (advance) begin
                    idx_d = idx_q + 5'd1;
                    case (pb_idx)
                        8'd1: begin
                            shadow_d.video_format               = byte_data[6:5];
                            shadow_d.active_format_info_present = byte_data[4];
                            shadow_d.bar_info                   = byte_data[3:2];
                            shadow_d.scan_info                  = byte_data[1:0];
                        end
                        8'd2: begin
                            shadow_d.colorimetry                = byte_data[7:6];
                            shadow_d.picture_aspect_ratio       = byte_data[5:4];
                            shadow_d.active_format_aspect_ratio = byte_data[3:0];
                        end
                        8'd3: begin
                            shadow_d.it_content                  = byte_data[7];
                            shadow_d.extended_colorimetry        = byte_data[6:4];
                            shadow_d.rgb_quantization_range      = byte_data[3:2];
                            shadow_d.non_uniform_picture_scaling = byte_data[1:0];
                        end
                        8'd4: shadow_d.cea = byte_data;
                        8'd5: begin
                            shadow_d.ycc_quantization_range = byte_data[7:6];
                            shadow_d.content_type           = byte_data[5:4];
                            shadow_d.pixel_repetition       = byte_data[3:0];
                        end
                        default: ;
                    endcase
                    if (idx_q == LAST_BYTE_INDEX) begin
                        idx_d   = 5'd0;
                        state_d = ST_DONE;
                        if (hdr_bad) begin
                            err_header_d = 1'b1;
                        end else if (acc_sum_next != 8'd0) begin
                            err_checksum_d = 1'b1;
                        end else begin
                            live_d         = shadow_q;
                            frame_update_d = 1'b1;
                            frame_valid_d  = 1'b1;
                        end
                    end
                end
                ST_SKIP: if (advance) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == LAST_BYTE_INDEX) begin
                        idx_d   = 5'd0;
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= 5'd0;
            ver_q          <= 8'd0;
            len_q          <= 8'd0;
            shadow_q       <= '0;
            live_q         <= '0;
            frame_valid_q  <= 1'b0;
            frame_update_q <= 1'b0;
            err_checksum_q <= 1'b0;
            err_header_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            ver_q          <= ver_d;
            len_q          <= len_d;
            shadow_q       <= shadow_d;
            live_q         <= live_d;
            frame_valid_q  <= frame_valid_d;
            frame_update_q <= frame_update_d;
            err_checksum_q <= err_checksum_d;
            err_header_q   <= err_header_d;
        end
    end

    assign video_format                = live_q.video_format;
    assign active_format_info_present  = live_q.active_format_info_present;
    assign bar_info                    = live_q.bar_info;
    assign scan_info                   = live_q.scan_info;
    assign colorimetry                 = live_q.colorimetry;
    assign picture_aspect_ratio        = live_q.picture_aspect_ratio;
    assign active_format_aspect_ratio  = live_q.active_format_aspect_ratio;
    assign it_content                  = live_q.it_content;
    assign extended_colorimetry        = live_q.extended_colorimetry;
    assign rgb_quantization_range      = live_q.rgb_quantization_range;
    assign non_uniform_picture_scaling = live_q.non_uniform_picture_scaling;
    assign cea                         = live_q.cea;
    assign ycc_quantization_range      = live_q.ycc_quantization_range;
    assign content_type                = live_q.content_type;
    assign pixel_repetition            = live_q.pixel_repetition;
    assign frame_valid                 = frame_valid_q;
    assign frame_update                = frame_update_q;
    assign err_checksum                = err_checksum_q;
    assign err_header                  = err_header_q;

`ifdef AVI_INFO_FRAME_RX_STATS_EN
    logic [ERR_CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] cksum_err_cnt_q, cksum_err_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] hdr_err_cnt_q, hdr_err_cnt_d;

    // Saturating event counters, bumped on each outcome pulse.
    always_comb begin
        good_cnt_d      = good_cnt_q;
        cksum_err_cnt_d = cksum_err_cnt_q;
        hdr_err_cnt_d   = hdr_err_cnt_q;
        if (frame_update_q && good_cnt_q != '1)      good_cnt_d      = good_cnt_q + 1'b1;
        if (err_checksum_q && cksum_err_cnt_q != '1) cksum_err_cnt_d = cksum_err_cnt_q + 1'b1;
        if (err_header_q && hdr_err_cnt_q != '1)     hdr_err_cnt_d   = hdr_err_cnt_q + 1'b1;
    end

    // Counter registers.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            good_cnt_q      <= '0;
            cksum_err_cnt_q <= '0;
            hdr_err_cnt_q   <= '0;
        end else begin
            good_cnt_q      <= good_cnt_d;
            cksum_err_cnt_q <= cksum_err_cnt_d;
            hdr_err_cnt_q   <= hdr_err_cnt_d;
        end
    end

    assign good_cnt      = good_cnt_q;
    assign cksum_err_cnt = cksum_err_cnt_q;
    assign hdr_err_cnt   = hdr_err_cnt_q;
`else
    // Counter width only matters when statistics are built in.
    if (ERR_CNT_WIDTH < 1) begin : g_err_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_avi_info_frame_receiver.sv
// Self-checking bench for avi_info_frame_receiver: table vectors, hand
// sequences for abort/gap/reset corners, and random packets against a
// byte-level reference model.
module tb_avi_info_frame_receiver;

    logic       clk_pixel = 1'b0;
    logic       reset, byte_valid, byte_sop;
    logic [7:0] byte_data;
    logic [1:0] video_format, bar_info, scan_info, colorimetry, picture_aspect_ratio;
    logic [1:0] rgb_quantization_range, non_uniform_picture_scaling;
    logic [1:0] ycc_quantization_range, content_type;
    logic [3:0] active_format_aspect_ratio, pixel_repetition;
    logic [2:0] extended_colorimetry;
    logic [7:0] cea;
    logic       active_format_info_present, it_content;
    logic       frame_valid, frame_update, err_checksum, err_header;

    avi_info_frame_receiver dut (
        .clk_pixel(clk_pixel), .reset(reset), .byte_valid(byte_valid),
        .byte_sop(byte_sop), .byte_data(byte_data),
        .video_format(video_format),
        .active_format_info_present(active_format_info_present),
        .bar_info(bar_info), .scan_info(scan_info), .colorimetry(colorimetry),
        .picture_aspect_ratio(picture_aspect_ratio),
        .active_format_aspect_ratio(active_format_aspect_ratio),
        .it_content(it_content), .extended_colorimetry(extended_colorimetry),
        .rgb_quantization_range(rgb_quantization_range),
        .non_uniform_picture_scaling(non_uniform_picture_scaling),
        .cea(cea), .ycc_quantization_range(ycc_quantization_range),
        .content_type(content_type), .pixel_repetition(pixel_repetition),
        .frame_valid(frame_valid), .frame_update(frame_update),
        .err_checksum(err_checksum), .err_header(err_header)
    );

    always #5 clk_pixel = ~clk_pixel;

    int total = 0;
    int bad   = 0;

    // Reference state: last accepted PB1..PB5 bytes and outcome counts.
    logic [7:0] m_pb [1:5];
    bit         m_valid;
    int         m_upd = 0, m_ck = 0, m_hdr = 0;
    int         mon_upd = 0, mon_ck = 0, mon_hdr = 0;
    logic [7:0] pkt [0:30];

    // Count every pulse the DUT ever raises, to catch stray ones.
    always @(posedge clk_pixel) begin
        mon_upd <= mon_upd + int'(frame_update);
        mon_ck  <= mon_ck + int'(err_checksum);
        mon_hdr <= mon_hdr + int'(err_header);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] dut_fields();
        return {video_format, active_format_info_present, bar_info, scan_info,
                colorimetry, picture_aspect_ratio, active_format_aspect_ratio,
                it_content, extended_colorimetry, rgb_quantization_range,
                non_uniform_picture_scaling, cea,
                ycc_quantization_range, content_type, pixel_repetition};
    endfunction

    function automatic logic [38:0] exp_fields();
        logic [7:0] b1;
        b1 = m_pb[1];
        return {b1[6:0], m_pb[2], m_pb[3], m_pb[4], m_pb[5]};
    endfunction

    // Build a packet whose PB0 makes the covered bytes sum to zero
    // (or to one when 'corrupt').
    task automatic build_pkt(input logic [7:0] hb0, hb1, hb2, p1, p2, p3, p4, p5,
                             input bit corrupt, input bit rand_tail);
        logic [7:0] s;
        int lim;
        pkt[0] = hb0; pkt[1] = hb1; pkt[2] = hb2;
        pkt[4] = p1; pkt[5] = p2; pkt[6] = p3; pkt[7] = p4; pkt[8] = p5;
        for (int i = 9; i < 31; i++) pkt[i] = rand_tail ? 8'($urandom) : 8'd0;
        lim = (hb2 > 8'd27) ? 27 : int'(hb2);
        s = hb0 + hb1 + hb2;
        for (int k = 1; k <= lim; k++) s = s + pkt[3 + k];
        pkt[3] = (8'd0 - s) + {7'd0, corrupt};
    endtask

    // 0 = ignored, 1 = accepted, 2 = checksum error, 3 = header error.
    function automatic int model_kind();
        logic [7:0] s;
        int lim;
        if (pkt[0] != 8'h82) return 0;
        if (pkt[1] != 8'd2 || pkt[2] < 8'd13 || pkt[2] > 8'd27) return 3;
        lim = int'(pkt[2]);
        s = 8'd0;
        for (int i = 0; i <= 3 + lim; i++) s = s + pkt[i];
        return (s == 8'd0) ? 1 : 2;
    endfunction

    task automatic apply_model(input int kind);
        case (kind)
            1: begin
                for (int i = 1; i <= 5; i++) m_pb[i] = pkt[3 + i];
                m_valid = 1'b1;
                m_upd++;
            end
            2: m_ck++;
            3: m_hdr++;
            default: ;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sop);
        @(negedge clk_pixel);
        byte_valid = 1'b1; byte_sop = sop; byte_data = d;
        @(posedge clk_pixel);
    endtask

    task automatic idle_cycle();
        @(negedge clk_pixel);
        byte_valid = 1'b0; byte_sop = 1'b0; byte_data = 8'($urandom);
        @(posedge clk_pixel);
    endtask

    // gap: 0 none, 1 alternate valid cycles, 2 random idle cycles.
    task automatic send_pkt(input int gap, input int upto);
        for (int i = 0; i < upto; i++) begin
            send_byte(pkt[i], i == 0);
            if (i < upto - 1) begin
                if (gap == 1) idle_cycle();
                if (gap == 2 && $urandom_range(0, 3) == 0) idle_cycle();
            end
        end
    endtask

    task automatic check_result(input string tag, input int kind);
        apply_model(kind);
        #1;
        check({tag, "/frame_update"}, 64'(frame_update), 64'(kind == 1));
        check({tag, "/err_checksum"}, 64'(err_checksum), 64'(kind == 2));
        check({tag, "/err_header"}, 64'(err_header), 64'(kind == 3));
        check({tag, "/fields"}, 64'(dut_fields()), 64'(exp_fields()));
        check({tag, "/frame_valid"}, 64'(frame_valid), 64'(m_valid));
    endtask

    task automatic check_cleared(input string tag);
        #1;
        check({tag, "/fields"}, 64'(dut_fields()), 64'd0);
        check({tag, "/frame_valid"}, 64'(frame_valid), 64'd0);
        check({tag, "/pulses"}, 64'({frame_update, err_checksum, err_header}), 64'd0);
    endtask

    typedef struct {
        logic [7:0] hb0, hb1, hb2, p1, p2, p3, p4, p5;
        bit         corrupt;
        bit         rand_tail;
        int         gap;
        int         kind;
    } vec_t;

    vec_t vt [9];

    initial begin
        reset = 1'b1; byte_valid = 1'b0; byte_sop = 1'b0; byte_data = 8'd0;
        for (int i = 1; i <= 5; i++) m_pb[i] = 8'd0;
        m_valid = 1'b0;

        // hb0 hb1 hb2 pb1 pb2 pb3 pb4 pb5 corrupt tail gap kind
        vt[0] = '{8'h82, 8'h02, 8'h0D, 8'h00, 8'h09, 8'h00, 8'h04, 8'h00, 1'b0, 1'b0, 0, 1};
        vt[1] = '{8'h82, 8'h02, 8'h0D, 8'h00, 8'h09, 8'h00, 8'h04, 8'h00, 1'b1, 1'b0, 0, 2};
        vt[2] = '{8'h82, 8'h03, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 1'b0, 1'b0, 0, 3};
        vt[3] = '{8'h82, 8'h02, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 1'b0, 1'b0, 0, 3};
        vt[4] = '{8'h82, 8'h02, 8'h1C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 1'b0, 1'b1, 0, 3};
        vt[5] = '{8'h82, 8'h02, 8'h1B, 8'hFF, 8'hA5, 8'h5A, 8'h90, 8'h3F, 1'b0, 1'b1, 1, 1};
        vt[6] = '{8'h84, 8'h01, 8'h19, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 1'b0, 1'b1, 0, 0};
        vt[7] = '{8'h82, 8'h02, 8'h0D, 8'h12, 8'h34, 8'h56, 8'h10, 8'h78, 1'b0, 1'b1, 0, 1};
        vt[8] = '{8'h82, 8'h02, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2, 2};

        repeat (3) @(posedge clk_pixel);
        check_cleared("reset");
        @(negedge clk_pixel);
        reset = 1'b0;
        idle_cycle();

        // Table vectors; even entries follow back-to-back so the next sop
        // lands in the DONE cycle.
        for (int v = 0; v < 9; v++) begin
            build_pkt(vt[v].hb0, vt[v].hb1, vt[v].hb2, vt[v].p1, vt[v].p2,
                      vt[v].p3, vt[v].p4, vt[v].p5, vt[v].corrupt, vt[v].rand_tail);
            send_pkt(vt[v].gap, 31);
            check_result($sformatf("vec%0d", v), vt[v].kind);
            if (v % 2 == 1) idle_cycle();
        end

        // sop at PB10 aborts a frame silently; the restarted frame is taken.
        build_pkt(8'h82, 8'h02, 8'h0D, 8'h40, 8'h2A, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0);
        send_pkt(0, 13);
        build_pkt(8'h82, 8'h02, 8'h0D, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0);
        send_pkt(0, 31);
        check_result("abort", 1);
        idle_cycle();

        // Alternating valid through a good frame, then reset mid-frame.
        build_pkt(8'h82, 8'h02, 8'h0D, 8'h20, 8'h19, 8'h8C, 8'h22, 8'h41, 1'b0, 1'b0);
        send_pkt(1, 31);
        check_result("toggle", 1);
        build_pkt(8'h82, 8'h02, 8'h0D, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        send_pkt(0, 10);
        @(negedge clk_pixel);
        byte_valid = 1'b0; byte_sop = 1'b0; reset = 1'b1;
        @(posedge clk_pixel);
        for (int i = 1; i <= 5; i++) m_pb[i] = 8'd0;
        m_valid = 1'b0;
        check_cleared("midreset");
        @(negedge clk_pixel);
        reset = 1'b0;
        build_pkt(8'h82, 8'h02, 8'h0E, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 1'b0, 1'b1);
        send_pkt(0, 31);
        check_result("postreset", 1);

        // Random packets against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [7:0] hb0, hb1, hb2;
            int kind;
            if ($urandom_range(0, 9) == 0) begin
                build_pkt(8'h82, 8'h02, 8'h0D, 8'($urandom), 8'($urandom), 8'($urandom),
                          8'($urandom), 8'($urandom), 1'b0, 1'b1);
                send_pkt(2, $urandom_range(1, 30));
            end
            hb0 = ($urandom_range(0, 7) == 0) ? 8'h84 : 8'h82;
            hb1 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h02;
            hb2 = 8'($urandom_range(10, 29));
            build_pkt(hb0, hb1, hb2, 8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, 1'b1);
            kind = model_kind();
            send_pkt(2, 31);
            check_result($sformatf("rnd%0d", n), kind);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        repeat (3) idle_cycle();
        check("pulse_count/update", 64'(mon_upd), 64'(m_upd));
        check("pulse_count/checksum", 64'(mon_ck), 64'(m_ck));
        check("pulse_count/header", 64'(mon_hdr), 64'(m_hdr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
